mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data) onto a single-ported synchronous memory.
// Data wins by default; a bounded streak counter stops fetch starvation.
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   output logic          if_stall,
   input  logic          dm_read,
   input  logic          dm_write,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   input  logic [3:0]    dm_be,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          dm_stall,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

   localparam logic [2:0] SMAX = 3'(STARVE_MAX);

   state_t        state, state_nx;
   logic [2:0]    streak, streak_nx;
   logic [DW-1:0] if_hold, dm_hold;
   logic          dm_req;

   assign dm_req = dm_read | dm_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         streak  <= '0;
         if_hold <= '0;
         dm_hold <= '0;
      end else begin
         state  <= state_nx;
         streak <= streak_nx;
         if (state == IF_BUSY) if_hold <= mem_rdata;
         if (state == DM_BUSY) dm_hold <= mem_rdata;
      end
   end

   always_comb begin
      state_nx  = state;
      streak_nx = streak;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if_done   = 1'b0;
      dm_done   = 1'b0;
      if_rdata  = if_hold;
      dm_rdata  = dm_hold;

      case (state)
         IDLE: begin
            // Fetch takes over only once the data streak has hit the limit.
            if (dm_req && !(if_req && streak == SMAX)) begin
               mem_en    = 1'b1;
               mem_we    = dm_write;
               mem_addr  = dm_addr;
               mem_wdata = dm_wdata;
               mem_be    = dm_write ? dm_be : 4'hF;
               state_nx  = DM_BUSY;
               if (if_req && streak != SMAX) streak_nx = streak + 3'd1;
            end else if (if_req) begin
               mem_en    = 1'b1;
               mem_addr  = if_addr;
               mem_be    = 4'hF;
               state_nx  = IF_BUSY;
               streak_nx = '0;
            end
            if (!if_req) streak_nx = '0;
         end
         IF_BUSY: begin
            if_done  = 1'b1;
            if_rdata = mem_rdata;
            state_nx = IDLE;
         end
         DM_BUSY: begin
            dm_done  = 1'b1;
            dm_rdata = mem_rdata;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if_stall = if_req & ~if_done;
      dm_stall = dm_req & ~dm_done;

      // Reset must force every output low without waiting for a clock edge.
      if (rst) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         mem_be    = '0;
         if_done   = 1'b0;
         dm_done   = 1'b0;
         if_stall  = 1'b0;
         dm_stall  = 1'b0;
         if_rdata  = '0;
         dm_rdata  = '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_done, if_stall;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          dm_read, dm_write, dm_done, dm_stall;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata, dm_rdata;
   logic [3:0]    dm_be;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [3:0]    mem_be;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] exp_if[$];
   logic [DW-1:0] exp_dm[$];
   logic          exp_g[$];

   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] mrd = '0;
   logic [DW-1:0] wword;
   logic          force_en;
   logic [DW-1:0] force_val;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = force_en ? force_val : mrd;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            wword = mem[mem_addr[9:2]];
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) wword[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr[9:2]] <= wword;
         end
         mrd <= mem[mem_addr[9:2]];
      end
   end

   function automatic logic [DW-1:0] init_word(int unsigned i);
      return {16'hC0DE, 16'(i)};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h40; dm_read = 1'b1; dm_addr = 32'h100;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
      checks++; if ({if_stall, dm_stall} !== 2'b00) begin errors++; $display("FAIL rst_stall got %b want 00", {if_stall, dm_stall}); end
      checks++; if ({if_done, dm_done, mem_we} !== 3'b000) begin errors++; $display("FAIL rst_done_we got %b want 000", {if_done, dm_done, mem_we}); end
      checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus got %h/%h/%h want 0", mem_addr, mem_be, mem_wdata); end
      checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0", if_rdata, dm_rdata); end
      if_req = 1'b0; dm_read = 1'b0; rst = 1'b0; #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_no_req got mem_en=%b want 0", mem_en); end
      step();
   endtask

   task automatic test_fetch();
      logic [DW-1:0] e;
      if_req = 1'b1; if_addr = 32'h40; exp_if.push_back(32'h00500093); #1;
      checks++; if ({mem_en, mem_we, mem_be} !== 6'b10_1111 || mem_addr !== 32'h40) begin errors++; $display("FAIL fetch_issue got en=%b we=%b be=%h addr=%h want 1 0 f 40", mem_en, mem_we, mem_be, mem_addr); end
      checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall0 got %b want 1", if_stall); end
      step(); #1;
      checks++; if ({if_done, if_stall, mem_en, dm_done} !== 4'b1000) begin errors++; $display("FAIL fetch_done got done/stall/en/dm=%b want 1000", {if_done, if_stall, mem_en, dm_done}); end
      e = (exp_if.size() > 0) ? exp_if.pop_front() : 32'hX;
      checks++; if (if_rdata !== e) begin errors++; $display("FAIL fetch_rdata got %h want %h", if_rdata, e); end
      if_req = 1'b0;
      step(); #1;
      checks++; if (if_done !== 1'b0 || if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_hold got done=%b rdata=%h want 0 00500093", if_done, if_rdata); end
   endtask

   task automatic test_collision();
      logic [DW-1:0] e;
      if_req = 1'b1; if_addr = 32'h44; dm_read = 1'b1; dm_addr = 32'h100;
      exp_dm.push_back(init_word(64)); exp_if.push_back(init_word(17)); #1;
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL coll_c0 got en=%b addr=%h want 1 100", mem_en, mem_addr); end
      step(); #1;
      e = (exp_dm.size() > 0) ? exp_dm.pop_front() : 32'hX;
      checks++; if (dm_done !== 1'b1 || dm_rdata !== e || if_done !== 1'b0) begin errors++; $display("FAIL coll_c1 got dm_done=%b rdata=%h if_done=%b want 1 %h 0", dm_done, dm_rdata, if_done, e); end
      dm_read = 1'b0;
      step(); #1;
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h44 || if_stall !== 1'b1) begin errors++; $display("FAIL coll_c2 got en=%b addr=%h stall=%b want 1 44 1", mem_en, mem_addr, if_stall); end
      step(); #1;
      e = (exp_if.size() > 0) ? exp_if.pop_front() : 32'hX;
      checks++; if (if_done !== 1'b1 || if_rdata !== e) begin errors++; $display("FAIL coll_c3 got if_done=%b rdata=%h want 1 %h", if_done, if_rdata, e); end
      if_req = 1'b0;
      step();
   endtask

   task automatic test_starve();
      int ngr = 0;
      int run = 0;
      int maxrun = 0;
      logic g, e;
      exp_g.push_back(1'b1); exp_g.push_back(1'b1); exp_g.push_back(1'b1);
      exp_g.push_back(1'b0); exp_g.push_back(1'b1);
      if_req = 1'b1; if_addr = 32'h48; dm_read = 1'b1; dm_addr = 32'h100;
      for (int c = 0; c < 40; c++) begin
         #1;
         checks++; if (if_done && dm_done) begin errors++; $display("FAIL both_done got 11 want not both"); end
         if (mem_en) begin
            g = (mem_addr == 32'h100);
            e = exp_g.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL grant_%0d got %s want %s", ngr, g ? "DM" : "IF", e ? "DM" : "IF"); end
            run = g ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            ngr++;
         end
         if (ngr == 5) break;
         step();
      end
      checks++; if (ngr != 5) begin errors++; $display("FAIL starve_timeout got %0d grants want 5", ngr); end
      checks++; if (maxrun > 3) begin errors++; $display("FAIL starve_run got %0d want <=3", maxrun); end
      step();
      dm_read = 1'b0; if_req = 1'b0;
      step();
   endtask

   task automatic test_write();
      logic [DW-1:0] iw, e;
      dm_write = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011; #1;
      checks++; if ({mem_en, mem_we, mem_be} !== 6'b11_0011 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h20) begin errors++; $display("FAIL wr_issue got en=%b we=%b be=%b wd=%h addr=%h want 1 1 0011 deadbeef 20", mem_en, mem_we, mem_be, mem_wdata, mem_addr); end
      step(); #1;
      checks++; if (dm_done !== 1'b1 || dm_stall !== 1'b0) begin errors++; $display("FAIL wr_done got done=%b stall=%b want 1 0", dm_done, dm_stall); end
      dm_write = 1'b0;
      step();
      dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h24; dm_wdata = 32'h12345678; dm_be = 4'b1100; #1;
      checks++; if (mem_we !== 1'b1 || mem_be !== 4'b1100) begin errors++; $display("FAIL rdwr_as_write got we=%b be=%b want 1 1100", mem_we, mem_be); end
      step();
      dm_read = 1'b0; dm_write = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         dm_read = 1'b1; dm_be = 4'b0000;
         if (k == 0) begin
            dm_addr = 32'h20; iw = init_word(8); exp_dm.push_back({iw[31:16], 16'hBEEF});
         end else begin
            dm_addr = 32'h24; iw = init_word(9); exp_dm.push_back({16'h1234, iw[15:0]});
         end
         #1;
         checks++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin errors++; $display("FAIL rd_issue_%0d got we=%b be=%h want 0 f", k, mem_we, mem_be); end
         step(); #1;
         e = (exp_dm.size() > 0) ? exp_dm.pop_front() : 32'hX;
         checks++; if (dm_done !== 1'b1 || dm_rdata !== e) begin errors++; $display("FAIL readback_%0d got done=%b rdata=%h want 1 %h", k, dm_done, dm_rdata, e); end
         dm_read = 1'b0;
         step();
      end
   endtask

   task automatic test_hold();
      logic [DW-1:0] e;
      mem[12] = 32'h1234;
      dm_read = 1'b1; dm_addr = 32'h30; exp_dm.push_back(32'h1234); #1;
      step(); #1;
      e = (exp_dm.size() > 0) ? exp_dm.pop_front() : 32'hX;
      checks++; if (dm_done !== 1'b1 || dm_rdata !== e) begin errors++; $display("FAIL hold_read got done=%b rdata=%h want 1 %h", dm_done, dm_rdata, e); end
      dm_read = 1'b0;
      step();
      force_val = 32'hFFFF; force_en = 1'b1; #1;
      checks++; if (dm_rdata !== 32'h1234) begin errors++; $display("FAIL hold_idle0 got %h want 00001234", dm_rdata); end
      step(); #1;
      checks++; if (dm_rdata !== 32'h1234) begin errors++; $display("FAIL hold_idle1 got %h want 00001234", dm_rdata); end
      force_en = 1'b0;
   endtask

   task automatic test_reset_busy();
      logic [DW-1:0] e;
      if_req = 1'b1; if_addr = 32'h40; #1;
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rb_issue got %b want 1", mem_en); end
      @(posedge clk); #2;
      rst = 1'b1; #1;
      checks++; if ({if_done, mem_en, if_stall} !== 3'b000 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rb_async got done/en/stall=%b rdata=%h/%h want 000 0 0", {if_done, mem_en, if_stall}, if_rdata, dm_rdata); end
      @(negedge clk); #1;
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL rb_no_done got %b want 0", if_done); end
      step();
      rst = 1'b0; exp_if.push_back(32'h00500093); #1;
      checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40 || if_stall !== 1'b1) begin errors++; $display("FAIL rb_reissue got en=%b addr=%h stall=%b want 1 40 1", mem_en, mem_addr, if_stall); end
      step(); #1;
      e = (exp_if.size() > 0) ? exp_if.pop_front() : 32'hX;
      checks++; if (if_done !== 1'b1 || if_rdata !== e) begin errors++; $display("FAIL rb_done got done=%b rdata=%h want 1 %h", if_done, if_rdata, e); end
      if_req = 1'b0;
      step();
   endtask

   initial begin
      for (int unsigned i = 0; i < 256; i++) mem[i] = init_word(i);
      mem[16] = 32'h00500093;
      rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
      dm_addr = '0; dm_wdata = '0; dm_be = '0; force_en = 1'b0; force_val = '0;
      test_reset();
      test_fetch();
      test_collision();
      test_starve();
      test_write();
      test_hold();
      test_reset_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
